// File: rtl/wisc_pkg.sv
// wisc_pkg: shared definitions for the WISC-SP22 front end.
// Provides the PC width, the HALT opcode, the NOP word that idle pipeline
// registers present, and the fetch state encoding.
package wisc_pkg;

  localparam int PC_W = 16;

  localparam logic [4:0]  OPC_HALT = 5'b00000;
  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HALTED,
    ERR
  } fetch_state_e;

  // HALT is recognised by its opcode field alone.
  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's bus-facing signals.
//   imem_*       request/response channel to instruction memory
//   redirect*    branch/jump target from execute
//   inst_*       valid/ready handshake towards decode, with the fetched word
//   halted/error status
// master = fetch unit side, slave = the environment (memory, execute, decode).
interface fetch_unit_if;
  import wisc_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rdy;
  logic            imem_valid;
  logic [15:0]     imem_data;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            inst_valid;
  logic [15:0]     instruction;
  logic [PC_W-1:0] pc_plus2;
  logic            inst_ready;
  logic            halted;
  logic            error;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, pc_plus2, halted, error,
    input  imem_rdy, imem_valid, imem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, pc_plus2, halted, error,
    output imem_rdy, imem_valid, imem_data, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: single-entry valid/ready holding register.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   load       capture load_data and present it as valid
//   load_data  word to capture
//   flush      drop the held word (wins over load)
//   ready      downstream consumes the word when valid & ready
//   valid      register holds a word
//   data       held word, stable while valid & ~ready
module fetch_out_reg
  import wisc_pkg::*;
#(
  parameter int               WIDTH     = 2 * PC_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             flush,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A load in the same cycle as a consume keeps valid high with the new word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the WISC-SP22 pipeline.
// Owns the PC, keeps at most one request outstanding to a variable-latency
// instruction memory, and hands fetched words to decode through
// fetch_out_reg. Stops on HALT, follows execute redirects, and locks in ERR
// on an odd redirect target or a response timeout.
// Ports:
//   clk  clock, all state on rising edge
//   rst  synchronous reset, active-low
//   bus  fetch_unit_if.master (memory, redirect, decode handshake, status)
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              TIMEOUT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  fetch_state_e        state;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     req_pc;
  logic [TIMER_W-1:0]  timer;
  logic                drop;

  logic                inst_valid;
  logic [2*PC_W-1:0]   out_word;

  logic out_free;
  logic req;
  logic accept;
  logic load;
  logic redir;
  logic timeout;
  logic go_err;
  logic flush;

  // A request only goes out when the output register is free next cycle,
  // so a response can always be captured; a redirect suppresses it so the
  // PC can take the new target cleanly.
  always_comb begin
    out_free = ~inst_valid | bus.inst_ready;
    redir    = bus.redirect & (state != ERR);
    req      = rst & (state == REQ) & out_free & ~bus.redirect;
    accept   = req & bus.imem_rdy;
    load     = (state == WAIT) & bus.imem_valid & ~drop & ~redir;
    // Fires on the TIMEOUT-th edge after the accepting edge.
    timeout  = (state == WAIT) & ~bus.imem_valid & ((int'(timer) + 1) >= TIMEOUT);
    go_err   = redir ? bus.redirect_pc[0] : timeout;
    flush    = redir | go_err;
  end

  // Redirect has priority over everything except ERR. A redirect while a
  // response is still in flight stays in WAIT with drop set, so the stale
  // word is swallowed and the single-outstanding rule holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      timer  <= '0;
      drop   <= 1'b0;
    end else if (redir) begin
      pc <= bus.redirect_pc;
      if (bus.redirect_pc[0]) begin
        state <= ERR;
      end else if (state == WAIT && !bus.imem_valid) begin
        drop  <= 1'b1;
        timer <= timer + 1'b1;
      end else begin
        state <= REQ;
        drop  <= 1'b0;
      end
    end else begin
      case (state)
        REQ: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + PC_W'(2);
            timer  <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_valid) begin
            drop  <= 1'b0;
            state <= (!drop && is_halt(bus.imem_data)) ? HALTED : REQ;
          end else if (timeout) begin
            state <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HALTED: ;
        ERR: ;
      endcase
    end
  end

  fetch_out_reg #(
    .WIDTH     (2 * PC_W),
    .RESET_VAL ({NOP_WORD, {PC_W{1'b0}}})
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data ({bus.imem_data, req_pc + PC_W'(2)}),
    .flush     (flush),
    .ready     (bus.inst_ready),
    .valid     (inst_valid),
    .data      (out_word)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.inst_valid  = inst_valid;
  assign bus.instruction = out_word[2*PC_W-1:PC_W];
  assign bus.pc_plus2    = out_word[PC_W-1:0];
  assign bus.halted      = (state == HALTED);
  assign bus.error       = (state == ERR);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the WISC-SP22 pipeline; it is the producer that feeds the 16-bit instruction word into decode.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Holds one fetched word in an output register under a valid/ready handshake.
- Accepts branch/jump redirects from execute.
- Stops on HALT (opcode 5'b00000).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 8, maximum cycles from request acceptance to response before error is raised (counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
imem_req  out  1  request valid to instruction memory
imem_addr  out  16  request address (current PC)
imem_rdy  in  1  memory accepts request this cycle (req & rdy = accepted)
imem_valid  in  1  response word valid (one cycle pulse)
imem_data  in  16  response instruction word
redirect  in  1  execute-stage branch taken / jump; overrides sequential PC
redirect_pc  in  16  redirect target
inst_valid  out  1  instruction register holds a word for decode
instruction  out  16  fetched word
pc_plus2  out  16  address of fetched word + 2 (for JAL/JALR link and branch base)
inst_ready  in  1  decode consumes word this cycle (valid & ready = transfer)
halted  out  1  fetch stopped on HALT
error  out  1  sticky: odd address or response timeout

Behaviour:
- Reset (rst==0): pc=RESET_PC, state=REQ, imem_req=0, inst_valid=0, instruction=16'h0800 (NOP), pc_plus2=0, halted=0, error=0, drop=0, timer=0.
- States: REQ, WAIT, HALTED, ERR.
- REQ:
  - imem_req=1, imem_addr=pc, but only when the output register is free next cycle, i.e. ~inst_valid | inst_ready. Otherwise imem_req=0.
  - On accept: latch req_pc=pc, pc<=pc+2 (16-bit wrap, 16'hFFFE+2=0), go to WAIT, timer=0.
- WAIT:
  - imem_req=0; timer increments each cycle.
  - On imem_valid with drop=0: instruction<=imem_data, pc_plus2<=req_pc+2, inst_valid<=1.
    - If imem_data[15:11]==5'b00000, go to HALTED; otherwise go to REQ.
    - Result: a new request can issue the cycle after the response, so latency is 2 cycles per instruction with a zero-wait memory.
  - On imem_valid with drop=1: discard the word, clear drop, go to REQ.
  - If timer reaches TIMEOUT with no response: error<=1, go to ERR.
- Output handshake: inst_valid clears on valid&ready unless a new word loads that same cycle. instruction and pc_plus2 are stable while valid&~ready.
- Redirect (highest priority, any state except ERR):
  - pc<=redirect_pc; inst_valid<=0, which squashes the held word.
  - If in WAIT and the response has not arrived this cycle, set drop=1 and stay in WAIT. A response arriving in the same cycle as the redirect is discarded.
  - From HALTED: clear halted, go to REQ.
  - If redirect_pc[0]==1: error<=1, go to ERR.
- Simultaneous redirect and request accept in REQ: redirect wins. No request is issued that cycle (imem_req gated low by redirect) and pc takes redirect_pc.
- HALTED: halted=1, imem_req=0. The HALT word stays presented until consumed once, then inst_valid=0. Remains halted until redirect or reset.
- ERR: imem_req=0, inst_valid=0, error=1. Exit only via reset.
- Reset mid-WAIT: the outstanding response is ignored. The memory model must not return it after reset; the bench drains it.
- Never more than one outstanding request; pc is always even outside ERR.

Decomposition:
- Shared package wisc_pkg:
  - OPC_HALT=5'b00000, NOP_WORD=16'h0800
  - fetch state enum {REQ, WAIT, HALTED, ERR}
  - PC width constant 16
- One sub-module is natural: fetch_out_reg, the single-entry valid/ready holding register with flush input, reusable by later pipeline registers.
- The FSM, pc and timer live in fetch_unit.

Test Plan:
- Zero-wait memory returning 16'hC001, 16'hD002, 16'hE003 at 0,2,4, inst_ready=1 -> three transfers at 2-cycle cadence, pc_plus2=2,4,6, imem_addr=0,2,4.
- Memory latency 3, inst_ready held 0 for 5 cycles after first word -> instruction/pc_plus2 stable, imem_req=0 until ready, no second request outstanding.
- Redirect to 16'h0040 while in WAIT for addr 0x0004 -> late response dropped, next imem_addr=0x0040, delivered pc_plus2=0x0042, no word from 0x0004 reaches decode.
- Fetch 16'h0000 at addr 0x000A -> inst_valid once with pc_plus2=0x000C, then halted=1 and imem_req=0; later redirect to 0x0020 -> halted=0, request at 0x0020.
- Memory never responds -> error=1 exactly TIMEOUT cycles after accept, imem_req stays 0; redirect_pc=16'h0013 on a fresh run -> error=1.
- rst=0 for one cycle mid-WAIT -> next cycle all outputs at reset values, first request at RESET_PC.
